// File: rtl/d16_issue.sv
// d16_issue: scoreboarded issue stage between d16_decode and execute; serialises jumps and flushes on taken ones.
// Optional macro D16_FORWARD_EN: a retiring writeback clears a matching read hazard in the same cycle.
module d16_issue #(
  parameter int unsigned NREG = 16,
  localparam int unsigned RW = $clog2(NREG)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          dec_valid,
  input  logic [7:0]    dec_op,
  input  logic [15:0]   dec_a,
  input  logic [15:0]   dec_b,
  input  logic [15:0]   dec_c,
  output logic          dec_ready,
  output logic          iss_valid,
  output logic [7:0]    iss_op,
  output logic [15:0]   iss_a,
  output logic [15:0]   iss_b,
  output logic [15:0]   iss_c,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_reg,
  input  logic          br_done,
  input  logic          br_taken,
  output logic          flush,
  output logic          err
);

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_SHL = 8'h03;
  localparam logic [7:0] OP_SHR = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05;
  localparam logic [7:0] OP_AND = 8'h06;
  localparam logic [7:0] OP_EQU = 8'h07;
  localparam logic [7:0] OP_LTE = 8'h08;
  localparam logic [7:0] OP_GTE = 8'h09;
  localparam logic [7:0] OP_LT  = 8'h0A;
  localparam logic [7:0] OP_GT  = 8'h0B;
  localparam logic [7:0] OP_AFC = 8'h0C;
  localparam logic [7:0] OP_COP = 8'h0D;
  localparam logic [7:0] OP_LOD = 8'h0E;
  localparam logic [7:0] OP_STR = 8'h0F;
  localparam logic [7:0] OP_LOP = 8'h10;
  localparam logic [7:0] OP_STP = 8'h11;
  localparam logic [7:0] OP_JMP = 8'h12;
  localparam logic [7:0] OP_JMZ = 8'h13;
  localparam logic [7:0] OP_JMR = 8'h14;

  typedef enum logic [1:0] {S_RUN, S_BRWAIT, S_FLUSH} state_t;

  state_t          state;
  logic [1:0]      cnt [NREG];
  logic            rd_b, rd_c, wr_a, is_jmp;
  logic [NREG-1:0] busy, inc, dec;
  logic [RW-1:0]   rb, rc, wa;
  logic            hazard;

  assign rb = dec_b[RW-1:0];
  assign rc = dec_c[RW-1:0];
  assign wa = dec_a[RW-1:0];

  // Operand usage per opcode class
  always_comb begin
    rd_b   = 1'b0;
    rd_c   = 1'b0;
    wr_a   = 1'b0;
    is_jmp = 1'b0;
    case (dec_op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND,
      OP_EQU, OP_LTE, OP_GTE, OP_LT, OP_GT: begin
        rd_b = 1'b1;
        rd_c = 1'b1;
        wr_a = 1'b1;
      end
      OP_AFC, OP_LOD: wr_a = 1'b1;
      OP_COP: begin
        rd_b = 1'b1;
        wr_a = 1'b1;
      end
      OP_LOP: begin
        rd_c = 1'b1;
        wr_a = 1'b1;
      end
      OP_STP: begin
        rd_b = 1'b1;
        rd_c = 1'b1;
      end
      OP_STR: rd_b = 1'b1;
      OP_JMZ, OP_JMR: begin
        rd_b   = 1'b1;
        is_jmp = 1'b1;
      end
      OP_JMP: is_jmp = 1'b1;
      default: ;
    endcase
  end

  // Per-register read-busy flags and counter increment/decrement requests
  always_comb begin
    busy = '0;
    inc  = '0;
    dec  = '0;
    for (int i = 0; i < NREG; i++) begin
      busy[i] = (cnt[i] != 2'd0);
`ifdef D16_FORWARD_EN
      if (wb_valid && wb_reg == RW'(i) && cnt[i] == 2'd1) busy[i] = 1'b0;
`endif
      inc[i] = dec_ready && wr_a && (wa == RW'(i));
      dec[i] = wb_valid && (wb_reg == RW'(i));
    end
  end

  // The writer limit is never forwarded: a full counter only frees up the cycle after writeback
  assign hazard    = (rd_b && busy[rb]) || (rd_c && busy[rc]) || (wr_a && cnt[wa] == 2'd3);
  assign dec_ready = dec_valid && (state == S_RUN) && !hazard;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_RUN;
      cnt       <= '{default: 2'd0};
      iss_valid <= 1'b0;
      iss_op    <= 8'd0;
      iss_a     <= 16'd0;
      iss_b     <= 16'd0;
      iss_c     <= 16'd0;
      flush     <= 1'b0;
      err       <= 1'b0;
    end else begin
      iss_valid <= dec_ready;
      flush     <= 1'b0;
      if (dec_ready) begin
        iss_op <= dec_op;
        iss_a  <= dec_a;
        iss_b  <= dec_b;
        iss_c  <= dec_c;
      end

      case (state)
        S_RUN: if (dec_ready && is_jmp) state <= S_BRWAIT;
        S_BRWAIT: begin
          if (br_done) begin
            if (br_taken) begin
              state <= S_FLUSH;
              flush <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_FLUSH: state <= S_RUN;
        default: state <= S_RUN;
      endcase

      if (wb_valid && cnt[wb_reg] == 2'd0) err <= 1'b1;

      // Simultaneous accept and writeback on one register cancel out
      for (int i = 0; i < NREG; i++) begin
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 2'd1;
        else if (dec[i] && !inc[i] && cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_d16_issue.sv
// Testbench for d16_issue: directed scenarios plus randomized traffic against a queue-free arithmetic reference model.
module tb_d16_issue;

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_SHL = 8'h03, OP_SHR = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h05, OP_AND = 8'h06, OP_EQU = 8'h07, OP_LTE = 8'h08;
  localparam logic [7:0] OP_GTE = 8'h09, OP_LT  = 8'h0A, OP_GT  = 8'h0B, OP_AFC = 8'h0C;
  localparam logic [7:0] OP_COP = 8'h0D, OP_LOD = 8'h0E, OP_STR = 8'h0F, OP_LOP = 8'h10;
  localparam logic [7:0] OP_STP = 8'h11, OP_JMP = 8'h12, OP_JMZ = 8'h13, OP_JMR = 8'h14;
  localparam logic [7:0] OP_NOP = 8'h00, OP_BAD = 8'hFF;

`ifdef D16_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst, dec_valid, dec_ready, iss_valid;
  logic [7:0]  dec_op, iss_op;
  logic [15:0] dec_a, dec_b, dec_c, iss_a, iss_b, iss_c;
  logic        wb_valid, br_done, br_taken, flush, err;
  logic [3:0]  wb_reg;

  d16_issue dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_a(dec_a), .dec_b(dec_b), .dec_c(dec_c),
    .dec_ready(dec_ready),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .br_done(br_done), .br_taken(br_taken),
    .flush(flush), .err(err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          m_cnt [16];
  bit          m_wait, m_flushing, m_err;
  bit          e_iss_valid, e_flush;
  logic [7:0]  e_op;
  logic [15:0] e_a, e_b, e_c;

  function automatic bit reads_b(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU, OP_LTE, OP_GTE,
                      OP_LT, OP_GT, OP_COP, OP_STP, OP_STR, OP_JMZ, OP_JMR};
  endfunction
  function automatic bit reads_c(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU, OP_LTE, OP_GTE,
                      OP_LT, OP_GT, OP_LOP, OP_STP};
  endfunction
  function automatic bit writes_a(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU, OP_LTE, OP_GTE,
                      OP_LT, OP_GT, OP_AFC, OP_LOD, OP_COP, OP_LOP};
  endfunction
  function automatic bit is_jump(input logic [7:0] op);
    return op inside {OP_JMP, OP_JMZ, OP_JMR};
  endfunction

  function automatic bit reg_blocked(input int r, input bit wv, input int wr);
    if (m_cnt[r] == 0) return 1'b0;
    if (FWD && wv && wr == r && m_cnt[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready(input bit v, input logic [7:0] op, input logic [15:0] a, b, c,
                                     input bit wv, input logic [3:0] wr);
    if (!v || m_wait || m_flushing) return 1'b0;
    if (reads_b(op) && reg_blocked(int'(b[3:0]), wv, int'(wr))) return 1'b0;
    if (reads_c(op) && reg_blocked(int'(c[3:0]), wv, int'(wr))) return 1'b0;
    if (writes_a(op) && m_cnt[a[3:0]] >= 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_wait = 0; m_flushing = 0; m_err = 0;
    e_iss_valid = 0; e_flush = 0;
    e_op = '0; e_a = '0; e_b = '0; e_c = '0;
  endtask

  task automatic model_step(input bit acc, input logic [7:0] op, input logic [15:0] a, b, c,
                            input bit wv, input logic [3:0] wr, input bit bd, bt);
    e_iss_valid = acc;
    if (acc) begin
      e_op = op; e_a = a; e_b = b; e_c = c;
    end
    e_flush = m_wait && bd && bt;
    if (m_wait) begin
      if (bd) begin
        m_wait = 0;
        m_flushing = bt;
      end
    end else if (m_flushing) begin
      m_flushing = 0;
    end else if (acc && is_jump(op)) begin
      m_wait = 1;
    end
    if (wv && m_cnt[wr] == 0) m_err = 1;
    if (acc && writes_a(op)) m_cnt[a[3:0]]++;
    if (wv && m_cnt[wr] > 0) m_cnt[wr]--;
  endtask

  // One clock: drive inputs, check dec_ready, advance model, then check registered outputs
  task automatic cycle(input bit v, input logic [7:0] op, input logic [15:0] a, b, c,
                       input bit wv, input logic [3:0] wr, input bit bd, bt, rst, output bit rdy);
    bit m_rdy;
    dec_valid = v; dec_op = op; dec_a = a; dec_b = b; dec_c = c;
    wb_valid = wv; wb_reg = wr; br_done = bd; br_taken = bt; sys_rst = rst;
    #1;
    m_rdy = model_ready(v, op, a, b, c, wv, wr);
    rdy = dec_ready;
    check("dec_ready", 32'(dec_ready), 32'(m_rdy));
    if (rst) model_reset();
    else model_step(m_rdy, op, a, b, c, wv, wr, bd, bt);
    @(posedge sys_clk);
    #1;
    check("iss_valid", 32'(iss_valid), 32'(e_iss_valid));
    if (e_iss_valid) begin
      check("iss_op", 32'(iss_op), 32'(e_op));
      check("iss_a", 32'(iss_a), 32'(e_a));
      check("iss_b", 32'(iss_b), 32'(e_b));
      check("iss_c", 32'(iss_c), 32'(e_c));
    end
    check("flush", 32'(flush), 32'(e_flush));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    bit r;
    cycle(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 1, r);
  endtask

  task automatic idle(output bit r);
    cycle(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  logic [7:0] ops [22] = '{OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_OR, OP_AND, OP_EQU, OP_LTE, OP_GTE,
                           OP_LT, OP_GT, OP_AFC, OP_COP, OP_LOD, OP_STR, OP_LOP, OP_STP, OP_JMP,
                           OP_JMZ, OP_JMR, OP_NOP, OP_BAD};

  bit          r, r2, hold, v, wv, bd, bt, rst;
  logic [7:0]  op;
  logic [15:0] fa, fb, fc;
  logic [3:0]  wr;

  initial begin
    model_reset();
    dec_valid = 0; dec_op = 0; dec_a = 0; dec_b = 0; dec_c = 0;
    wb_valid = 0; wb_reg = 0; br_done = 0; br_taken = 0; sys_rst = 1;
    @(posedge sys_clk);
    #1;
    do_reset();
    check("rst_iss_valid", 32'(iss_valid), 32'(0));
    check("rst_iss_op", 32'(iss_op), 32'(0));
    check("rst_flush", 32'(flush), 32'(0));
    check("rst_err", 32'(err), 32'(0));

    // Independent ops issue back to back
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 0, r);
    check("indep_acc0", 32'(r), 32'(1));
    cycle(1, OP_ADD, 4, 5, 6, 0, 0, 0, 0, 0, r);
    check("indep_acc1", 32'(r), 32'(1));
    check("indep_iss1", 32'(iss_valid), 32'(1));
    cycle(1, OP_COP, 8, 1, 0, 0, 0, 0, 0, 0, r);
    check("cnt1_pending", 32'(r), 32'(0));
    cycle(1, OP_LOP, 9, 0, 4, 0, 0, 0, 0, 0, r);
    check("cnt4_pending", 32'(r), 32'(0));

    // RAW stall resolved by writeback of reg 1
    do_reset();
    cycle(1, OP_AFC, 1, 0, 0, 0, 0, 0, 0, 0, r);
    check("raw_afc", 32'(r), 32'(1));
    cycle(1, OP_ADD, 2, 1, 3, 0, 0, 0, 0, 0, r);
    check("raw_stall0", 32'(r), 32'(0));
    cycle(1, OP_ADD, 2, 1, 3, 0, 0, 0, 0, 0, r);
    check("raw_stall1", 32'(r), 32'(0));
    cycle(1, OP_ADD, 2, 1, 3, 1, 1, 0, 0, 0, r);
    check("raw_wb_cycle", 32'(r), 32'(FWD));
    cycle(!r, OP_ADD, 2, 1, 3, 0, 0, 0, 0, 0, r2);
    check("raw_after_wb", 32'(r2), 32'(!FWD));

    // Pending counter limit of 3
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, OP_AFC, 7, 0, 0, 0, 0, 0, 0, 0, r);
      check("afc_fill", 32'(r), 32'(1));
    end
    cycle(1, OP_AFC, 7, 0, 0, 0, 0, 0, 0, 0, r);
    check("afc_limit", 32'(r), 32'(0));
    cycle(1, OP_AFC, 7, 0, 0, 1, 7, 0, 0, 0, r);
    check("afc_limit_wb", 32'(r), 32'(0));
    cycle(1, OP_AFC, 7, 0, 0, 0, 0, 0, 0, 0, r);
    check("afc_after_wb", 32'(r), 32'(1));
    cycle(1, OP_AFC, 7, 0, 0, 0, 0, 0, 0, 0, r);
    check("cnt7_stays3", 32'(r), 32'(0));

    // Taken jump: wait, flush pulse, resume
    do_reset();
    cycle(1, OP_JMZ, 0, 0, 0, 0, 0, 0, 0, 0, r);
    check("jmp_acc", 32'(r), 32'(1));
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 0, r);
    check("jmp_wait0", 32'(r), 32'(0));
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 0, r);
    check("jmp_wait1", 32'(r), 32'(0));
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 1, 1, 0, r);
    check("jmp_wait2", 32'(r), 32'(0));
    check("flush_pulse", 32'(flush), 32'(1));
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 0, r);
    check("flush_block", 32'(r), 32'(0));
    check("flush_end", 32'(flush), 32'(0));
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 0, r);
    check("post_flush_acc", 32'(r), 32'(1));

    // Not-taken jump resumes the next cycle
    cycle(1, OP_JMP, 0, 0, 0, 0, 0, 0, 0, 0, r);
    cycle(1, OP_NOP, 0, 0, 0, 0, 0, 1, 0, 0, r);
    check("nt_wait", 32'(r), 32'(0));
    cycle(1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, r);
    check("nt_resume", 32'(r), 32'(1));

    // Spurious writeback sets sticky err
    do_reset();
    cycle(0, OP_NOP, 0, 0, 0, 1, 9, 0, 0, 0, r);
    check("err_set", 32'(err), 32'(1));
    for (int i = 0; i < 3; i++) idle(r);
    check("err_sticky", 32'(err), 32'(1));
    do_reset();
    check("err_cleared", 32'(err), 32'(0));

    // Reset while waiting on a jump
    cycle(1, OP_AFC, 5, 0, 0, 0, 0, 0, 0, 0, r);
    cycle(1, OP_JMP, 0, 0, 0, 0, 0, 0, 0, 0, r);
    cycle(1, OP_ADD, 1, 2, 3, 0, 0, 0, 0, 1, r);
    check("rstbr_iss", 32'(iss_valid), 32'(0));
    check("rstbr_flush", 32'(flush), 32'(0));
    cycle(1, OP_COP, 6, 5, 0, 0, 0, 0, 0, 0, r);
    check("rstbr_cleared", 32'(r), 32'(1));

    // Randomized traffic against the model
    do_reset();
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!hold) begin
        v  = ($urandom_range(0, 7) != 0);
        op = ops[$urandom_range(0, 21)];
        fa = 16'($urandom); fa[3:0] = 4'($urandom_range(0, 3));
        fb = 16'($urandom); fb[3:0] = 4'($urandom_range(0, 3));
        fc = 16'($urandom); fc[3:0] = 4'($urandom_range(0, 3));
      end
      wr = 4'($urandom_range(0, 3));
      wv = ($urandom_range(0, 2) == 0) && (m_cnt[wr] > 0);
      if ($urandom_range(0, 400) == 0) begin
        wv = 1;
        wr = 4'($urandom_range(0, 15));
      end
      bd = ($urandom_range(0, 3) == 0);
      bt = 1'($urandom_range(0, 1));
      cycle(v, op, fa, fb, fc, wv, wr, bd, bt, rst, r);
      hold = v && !r && !rst;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/d16_issue.md
# d16_issue

Issue controller between `d16_decode` and the execute stage of the d16 core. It holds each decoded instruction until its register operands are free, using a per-register pending-write scoreboard. It serialises jumps until execute resolves them and flushes the front end on a taken jump. It registers the issued instruction towards execute.

## Interface
- `NREG`, 16, number of architectural registers; power of two; register index = low log2(NREG) bits of an operand field.
- `sys_clk`  in  1  clock.
- `sys_rst`  in  1  reset, synchronous and active-high.
- `dec_valid`  in  1  decode presents an instruction.
- `dec_op`  in  8  opcode (`D16_OP_*` from d16.vh).
- `dec_a`, `dec_b`, `dec_c`  in  16 each  decoded operand fields.
- `dec_ready`  out  1  instruction accepted this cycle (combinational).
- `iss_valid`  out  1  registered: instruction issued to execute.
- `iss_op`  out  8  registered copy of the accepted opcode.
- `iss_a`, `iss_b`, `iss_c`  out  16 each  registered copies of the accepted operand fields.
- `wb_valid`  in  1  writeback retires one register write.
- `wb_reg`  in  log2(NREG)  register retired.
- `br_done`  in  1  execute resolved the outstanding jump.
- `br_taken`  in  1  qualifies `br_done`: jump taken.
- `flush`  out  1  registered: discard fetch/decode contents.
- `err`  out  1  sticky: `wb_valid` arrived on a register with pending count 0.

## Operation
- **Operand classes**
  - ADD, SUB, SHL, SHR, OR, AND, EQU, LTE, GTE, LT, GT: read b and c, write a.
  - AFC, LOD: write a, no reads.
  - COP: reads b, writes a.
  - LOP: reads c, writes a.
  - STP: reads b and c.
  - STR: reads b.
  - JMZ, JMR: read b; jump.
  - JMP: no reads; jump.
  - All other opcodes: no reads, no writes.
- **Scoreboard**
  - One 2-bit pending counter per register.
  - Accepting a writer increments `cnt[a]`; `wb_valid` decrements `cnt[wb_reg]`.
  - When both hit the same register in the same cycle, the counter is unchanged.
  - `wb_valid` with count 0: counter stays 0 and `err` is set.
- **Hazard**
  - A read register with count ≠ 0 blocks issue.
  - A writer whose `cnt[a]` = 3 blocks issue; the counter never saturates past 3.
- **FSM states**
  - RUN: `dec_ready` = `dec_valid` & no hazard. Accepting a jump moves to BRWAIT; otherwise stay in RUN.
  - BRWAIT: `dec_ready` = 0. On `br_done` & `br_taken`, go to FLUSH. On `br_done` & !`br_taken`, go to RUN.
  - FLUSH: `dec_ready` = 0 for exactly one cycle, then RUN.
- `flush` = 1 during the cycle the FSM is in FLUSH.
- `br_done` outside BRWAIT is ignored.

## Timing
- **Reset values:** state RUN; all counters 0; `iss_valid`=0; `iss_op`/`iss_a`/`iss_b`/`iss_c`=0; `flush`=0; `err`=0.
- **Reset mid-jump** (BRWAIT or FLUSH) returns to RUN with counters cleared.
- **Latency:** acceptance in cycle N gives `iss_valid`=1 with the fields in cycle N+1. `iss_valid`=0 in any cycle following no acceptance.
- **Issue rate:** back-to-back acceptance, one instruction per cycle, in RUN with no hazards.
- **Scoreboard visibility:** an accept in cycle N is seen by hazard checks in cycle N+1. A writer followed by a dependent reader therefore always stalls at least until writeback.
- **Jump turnaround:** a jump accepted in cycle N enters BRWAIT at N+1. If `br_done` & `br_taken` arrive in cycle M, `flush`=1 in M+1 and the next accept is possible at M+2. A not-taken resolution at M allows accept at M+1.
- **Decode stability:** `dec_*` must stay stable while `dec_valid` & !`dec_ready`.

## Configuration
- **`D16_FORWARD_EN` defined:**
  - A read hazard on register r is cleared in the same cycle when `wb_valid` & `wb_reg`=r & `cnt[r]`=1; execute receives the writeback value by bypass.
  - `dec_ready` then depends combinationally on `wb_valid`/`wb_reg`.
- **Not defined:** the reader waits until the cycle after the counter reaches 0. `dec_ready` does not depend on `wb_*`.

## Test plan
- **Independent ops:** ADD a=1,b=2,c=3 then ADD a=4,b=5,c=6 on consecutive cycles → two accepts and `iss_valid` high for two consecutive cycles; cnt[1]=cnt[4]=1.
- **RAW stall:** AFC a=1 then ADD a=2,b=1,c=3, with writeback of reg 1 in cycle 5 → ADD stalls. It is accepted in cycle 5 with `D16_FORWARD_EN`, in cycle 6 without.
- **Counter limit:** three AFC a=7 with no writeback → the fourth AFC a=7 stalls; one `wb_reg`=7 → it issues the next cycle and cnt[7] stays 3.
- **Taken jump:** JMZ b=0 accepted, `br_done`=`br_taken`=1 three cycles later → `dec_ready`=0 throughout, `flush` pulses one cycle, next instruction accepted the cycle after.
- **Spurious writeback:** `wb_valid` with `wb_reg`=9 and cnt[9]=0 → `err`=1 and remains 1 until `sys_rst`.
- **Reset in BRWAIT:** pulse `sys_rst` while in BRWAIT → next cycle state is RUN, `iss_valid`=0, `flush`=0, all counters 0.
